// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter
// Round-robin arbiter between the audio playback reader and the sample recorder
// for one asynchronous cellular RAM. Each grant performs a single 16-bit word
// access: strobes held for WAIT_CYCLES+1 cycles, then one RECOVER cycle that
// carries the ack (and keeps write data on the bus for hold time).
//
// state      | meaning
// -----------+----------------------------------------------------------------
// S_IDLE     | strobes inactive, bus released, arbitrating pending requests
// S_RD_ACCESS| OE/CS/byte lanes low, counting out the read access time
// S_WR_ACCESS| WE/CS/byte lanes low, driving latched write word on MemDB
// S_RECOVER  | strobes inactive, ack pulse to served port, write data held
module ram_port_arbiter #(
    parameter int WAIT_CYCLES = 6,
    parameter int CNT_W       = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rd_req,
    input  logic [22:0] rd_addr,
    output logic        rd_ack,
    output logic [15:0] rd_data,
    input  logic        wr_req,
    input  logic [22:0] wr_addr,
    input  logic [15:0] wr_data,
    output logic        wr_ack,
    output logic        busy,
    output logic [22:0] MemAdr,
    inout  wire  [15:0] MemDB,
    output logic        RamAdv,
    output logic        RamClk,
    output logic        RamCS,
    output logic        MemOE,
    output logic        MemWR,
    output logic        RamLB,
    output logic        RamUB
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RD_ACCESS,
        S_WR_ACCESS,
        S_RECOVER
    } state_t;

    // Control vector order: {RamAdv, RamClk, RamCS, MemOE, MemWR, RamLB, RamUB}
    localparam logic [6:0]       CTRL_IDLE = 7'b1111111;
    localparam logic [6:0]       CTRL_RD   = 7'b0000100;
    localparam logic [6:0]       CTRL_WR   = 7'b0001000;
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(WAIT_CYCLES);

    state_t            r_state,   w_state_nxt;
    logic [CNT_W-1:0]  r_cnt,     w_cnt_nxt;
    logic [6:0]        r_ctrl,    w_ctrl_nxt;
    logic              r_db_oe,   w_db_oe_nxt;
    logic              r_rd_ack,  w_rd_ack_nxt;
    logic              r_wr_ack,  w_wr_ack_nxt;
    logic [15:0]       r_rd_data, w_rd_data_nxt;
    logic [22:0]       r_adr,     w_adr_nxt;
    logic [15:0]       r_wr_data, w_wr_data_nxt;
    logic              r_last_wr, w_last_wr_nxt;
    logic              r_busy,    w_busy_nxt;

    // Next-state and next-output computation; every output is registered below.
    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_ctrl_nxt    = r_ctrl;
        w_db_oe_nxt   = r_db_oe;
        w_rd_ack_nxt  = 1'b0;
        w_wr_ack_nxt  = 1'b0;
        w_rd_data_nxt = r_rd_data;
        w_adr_nxt     = r_adr;
        w_wr_data_nxt = r_wr_data;
        w_last_wr_nxt = r_last_wr;

        case (r_state)
            S_IDLE: begin
                w_ctrl_nxt  = CTRL_IDLE;
                w_db_oe_nxt = 1'b0;
                // On a tie the port that was not served last wins.
                if (rd_req && (!wr_req || r_last_wr)) begin
                    w_state_nxt   = S_RD_ACCESS;
                    w_adr_nxt     = rd_addr;
                    w_last_wr_nxt = 1'b0;
                    w_cnt_nxt     = '0;
                    w_ctrl_nxt    = CTRL_RD;
                end else if (wr_req) begin
                    w_state_nxt   = S_WR_ACCESS;
                    w_adr_nxt     = wr_addr;
                    w_wr_data_nxt = wr_data;
                    w_last_wr_nxt = 1'b1;
                    w_cnt_nxt     = '0;
                    w_ctrl_nxt    = CTRL_WR;
                    w_db_oe_nxt   = 1'b1;
                end
            end
            S_RD_ACCESS: begin
                if (r_cnt == CNT_LAST) begin
                    w_rd_data_nxt = MemDB;
                    w_state_nxt   = S_RECOVER;
                    w_ctrl_nxt    = CTRL_IDLE;
                    w_rd_ack_nxt  = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            S_WR_ACCESS: begin
                if (r_cnt == CNT_LAST) begin
                    // Bus stays driven through RECOVER for data hold time.
                    w_state_nxt  = S_RECOVER;
                    w_ctrl_nxt   = CTRL_IDLE;
                    w_wr_ack_nxt = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            S_RECOVER: begin
                w_state_nxt = S_IDLE;
                w_ctrl_nxt  = CTRL_IDLE;
                w_db_oe_nxt = 1'b0;
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_ctrl_nxt  = CTRL_IDLE;
                w_db_oe_nxt = 1'b0;
            end
        endcase

        w_busy_nxt = (w_state_nxt != S_IDLE);
    end

    // State and output registers; reset aborts any access in progress.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_ctrl    <= CTRL_IDLE;
            r_db_oe   <= 1'b0;
            r_rd_ack  <= 1'b0;
            r_wr_ack  <= 1'b0;
            r_rd_data <= '0;
            r_adr     <= '0;
            r_wr_data <= '0;
            r_last_wr <= 1'b1;
            r_busy    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_ctrl    <= w_ctrl_nxt;
            r_db_oe   <= w_db_oe_nxt;
            r_rd_ack  <= w_rd_ack_nxt;
            r_wr_ack  <= w_wr_ack_nxt;
            r_rd_data <= w_rd_data_nxt;
            r_adr     <= w_adr_nxt;
            r_wr_data <= w_wr_data_nxt;
            r_last_wr <= w_last_wr_nxt;
            r_busy    <= w_busy_nxt;
        end
    end

    assign {RamAdv, RamClk, RamCS, MemOE, MemWR, RamLB, RamUB} = r_ctrl;
    assign MemDB   = r_db_oe ? r_wr_data : 16'bz;
    assign MemAdr  = r_adr;
    assign rd_ack  = r_rd_ack;
    assign wr_ack  = r_wr_ack;
    assign rd_data = r_rd_data;
    assign busy    = r_busy;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Bench for ram_port_arbiter: 32-word RAM model on the low address bits,
// scoreboard queue of expected acks, bus-release probe on MemDB.
module tb_ram_port_arbiter;

    localparam int WAIT_CYCLES = 6;
    localparam int LAT         = WAIT_CYCLES + 2;
    localparam int SPACING     = WAIT_CYCLES + 3;

    typedef struct packed {
        logic        is_wr;
        logic [22:0] addr;
        logic [15:0] data;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rd_req = 1'b0;
    logic [22:0] rd_addr = '0;
    logic        rd_ack;
    logic [15:0] rd_data;
    logic        wr_req = 1'b0;
    logic [22:0] wr_addr = '0;
    logic [15:0] wr_data = '0;
    logic        wr_ack;
    logic        busy;
    logic [22:0] MemAdr;
    wire  [15:0] MemDB;
    logic        RamAdv, RamClk, RamCS, MemOE, MemWR, RamLB, RamUB;

    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc = 0;
    exp_t sb[$];

    logic [15:0] mem[32];
    logic        probe = 1'b0;
    wire         w_ram_rd = !MemOE && !RamCS && MemWR;
    wire  [6:0]  ctrl = {RamAdv, RamClk, RamCS, MemOE, MemWR, RamLB, RamUB};

    ram_port_arbiter #(.WAIT_CYCLES(WAIT_CYCLES), .CNT_W(3)) dut (
        .clk(clk), .rst_n(rst_n),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_ack(rd_ack), .rd_data(rd_data),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(wr_ack),
        .busy(busy), .MemAdr(MemAdr), .MemDB(MemDB),
        .RamAdv(RamAdv), .RamClk(RamClk), .RamCS(RamCS), .MemOE(MemOE),
        .MemWR(MemWR), .RamLB(RamLB), .RamUB(RamUB)
    );

    // RAM drives on read; otherwise the bench can drive a probe pattern,
    // which only reads back clean if the DUT has released the bus.
    assign MemDB = w_ram_rd ? mem[MemAdr[4:0]] : (probe ? 16'h5A5A : 16'hzzzz);

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!MemWR && !RamCS) mem[MemAdr[4:0]] = MemDB;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic test_reset;
        rst_n = 1'b0; rd_req = 1'b1; wr_req = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_cmp++; if (ctrl !== 7'b1111111) begin n_bad++; $display("FAIL reset_ctrl: got %b need 1111111", ctrl); end
        n_cmp++; if (rd_ack !== 1'b0 || wr_ack !== 1'b0) begin n_bad++; $display("FAIL reset_acks: got %b%b need 00", rd_ack, wr_ack); end
        n_cmp++; if (rd_data !== 16'h0) begin n_bad++; $display("FAIL reset_rd_data: got %h need 0000", rd_data); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b need 0", busy); end
        n_cmp++; if (MemAdr !== 23'h0) begin n_bad++; $display("FAIL reset_memadr: got %h need 0", MemAdr); end
        probe = 1'b1; #1;
        n_cmp++; if (MemDB !== 16'h5A5A) begin n_bad++; $display("FAIL reset_bus_release: got %h need 5a5a", MemDB); end
        probe = 1'b0;
        rd_req = 1'b0; wr_req = 1'b0; rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single_read;
        exp_t e;
        int   t0, oe_cnt, acks, wacks;
        mem[16] = 16'hA55A;
        @(negedge clk);
        rd_addr = 23'h10; rd_req = 1'b1; t0 = cyc;
        sb.push_back('{is_wr: 1'b0, addr: 23'h10, data: 16'hA55A});
        oe_cnt = 0; acks = 0; wacks = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (cyc == t0 + 3) begin
                rd_addr = 23'h0;
                n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL rd_busy: got %b need 1", busy); end
            end
            if (!MemOE) oe_cnt++;
            if (wr_ack) wacks++;
            if (rd_ack) begin
                acks++;
                rd_req = 1'b0;
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    n_cmp++; if (rd_data !== e.data) begin n_bad++; $display("FAIL rd_data: got %h need %h", rd_data, e.data); end
                    n_cmp++; if (MemAdr !== e.addr) begin n_bad++; $display("FAIL rd_memadr: got %h need %h", MemAdr, e.addr); end
                    n_cmp++; if (cyc - t0 != LAT) begin n_bad++; $display("FAIL rd_latency: got %0d need %0d", cyc - t0, LAT); end
                end
            end
        end
        n_cmp++; if (oe_cnt != WAIT_CYCLES + 1) begin n_bad++; $display("FAIL rd_oe_cycles: got %0d need %0d", oe_cnt, WAIT_CYCLES + 1); end
        n_cmp++; if (acks != 1) begin n_bad++; $display("FAIL rd_ack_count: got %0d need 1", acks); end
        n_cmp++; if (wacks != 0) begin n_bad++; $display("FAIL rd_stray_wr_ack: got %0d need 0", wacks); end
        n_cmp++; if (rd_data !== 16'hA55A) begin n_bad++; $display("FAIL rd_data_hold: got %h need a55a", rd_data); end
        sb.delete();
    endtask

    task automatic test_single_write;
        exp_t e;
        int   t0, we_cnt, db_bad, acks, racks;
        bit   chk_rel;
        mem[31] = 16'h0;
        @(negedge clk);
        wr_addr = 23'h7FFFFF; wr_data = 16'h1234; wr_req = 1'b1; t0 = cyc;
        sb.push_back('{is_wr: 1'b1, addr: 23'h7FFFFF, data: 16'h1234});
        we_cnt = 0; db_bad = 0; acks = 0; racks = 0; chk_rel = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (cyc == t0 + 3) wr_data = 16'hFFFF;
            if (!MemWR) begin
                we_cnt++;
                if (MemDB !== 16'h1234) db_bad++;
            end
            if (rd_ack) racks++;
            if (chk_rel) begin
                chk_rel = 1'b0;
                probe = 1'b1; #1;
                n_cmp++; if (MemDB !== 16'h5A5A) begin n_bad++; $display("FAIL wr_bus_release: got %h need 5a5a", MemDB); end
                probe = 1'b0;
            end
            if (wr_ack) begin
                acks++;
                wr_req = 1'b0;
                chk_rel = 1'b1;
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    n_cmp++; if (MemDB !== e.data) begin n_bad++; $display("FAIL wr_data_hold: got %h need %h", MemDB, e.data); end
                    n_cmp++; if (MemAdr !== e.addr) begin n_bad++; $display("FAIL wr_memadr: got %h need %h", MemAdr, e.addr); end
                    n_cmp++; if (cyc - t0 != LAT) begin n_bad++; $display("FAIL wr_latency: got %0d need %0d", cyc - t0, LAT); end
                end
            end
        end
        n_cmp++; if (we_cnt != WAIT_CYCLES + 1) begin n_bad++; $display("FAIL wr_we_cycles: got %0d need %0d", we_cnt, WAIT_CYCLES + 1); end
        n_cmp++; if (db_bad != 0) begin n_bad++; $display("FAIL wr_bus_data: got %0d bad cycles need 0", db_bad); end
        n_cmp++; if (mem[31] !== 16'h1234) begin n_bad++; $display("FAIL wr_model_word: got %h need 1234", mem[31]); end
        n_cmp++; if (acks != 1 || racks != 0) begin n_bad++; $display("FAIL wr_ack_count: got wr %0d rd %0d need 1 0", acks, racks); end
        sb.delete();
    endtask

    task automatic test_back_to_back;
        exp_t e;
        int   t_last, n_ack, both;
        @(negedge clk);
        rst_n = 1'b0; rd_req = 1'b1; wr_req = 1'b1;
        rd_addr = 23'h5; wr_addr = 23'h6; wr_data = 16'hBEEF;
        mem[5] = 16'h1111; mem[6] = 16'h0;
        repeat (2) @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            if (k % 2 == 0) sb.push_back('{is_wr: 1'b0, addr: 23'h5, data: 16'h1111});
            else            sb.push_back('{is_wr: 1'b1, addr: 23'h6, data: 16'hBEEF});
        end
        rst_n = 1'b1; t_last = cyc; n_ack = 0; both = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (rd_ack && wr_ack) both++;
            if (rd_ack || wr_ack) begin
                if (sb.size() == 0) begin
                    n_cmp++; n_bad++; $display("FAIL b2b_extra_ack: got ack rd %b wr %b need none", rd_ack, wr_ack);
                end else begin
                    e = sb.pop_front();
                    n_cmp++; if (wr_ack !== e.is_wr) begin n_bad++; $display("FAIL b2b_order: got wr_ack %b need %b (ack %0d)", wr_ack, e.is_wr, n_ack); end
                    n_cmp++; if (MemAdr !== e.addr) begin n_bad++; $display("FAIL b2b_memadr: got %h need %h", MemAdr, e.addr); end
                    if (!e.is_wr) begin
                        n_cmp++; if (rd_data !== e.data) begin n_bad++; $display("FAIL b2b_rd_data: got %h need %h", rd_data, e.data); end
                    end
                    n_cmp++; if (cyc - t_last != ((n_ack == 0) ? LAT : SPACING)) begin
                        n_bad++; $display("FAIL b2b_spacing: got %0d need %0d", cyc - t_last, (n_ack == 0) ? LAT : SPACING);
                    end
                end
                t_last = cyc;
                n_ack++;
                if (n_ack == 4) begin rd_req = 1'b0; wr_req = 1'b0; end
            end
        end
        n_cmp++; if (n_ack != 4) begin n_bad++; $display("FAIL b2b_ack_count: got %0d need 4", n_ack); end
        n_cmp++; if (both != 0) begin n_bad++; $display("FAIL b2b_dual_ack: got %0d need 0", both); end
        n_cmp++; if (mem[6] !== 16'hBEEF) begin n_bad++; $display("FAIL b2b_model_word: got %h need beef", mem[6]); end
        sb.delete();
    endtask

    task automatic test_reset_mid_access;
        exp_t e;
        int   t0, early, acks;
        @(negedge clk);
        mem[3] = 16'h0;
        wr_addr = 23'h3; wr_data = 16'hC0DE; wr_req = 1'b1; t0 = cyc; early = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (wr_ack) early++;
        end
        n_cmp++; if (MemWR !== 1'b0) begin n_bad++; $display("FAIL mid_in_access: got MemWR %b need 0", MemWR); end
        rst_n = 1'b0;
        @(negedge clk);
        if (wr_ack) early++;
        n_cmp++; if (ctrl !== 7'b1111111) begin n_bad++; $display("FAIL mid_ctrl: got %b need 1111111", ctrl); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL mid_busy: got %b need 0", busy); end
        probe = 1'b1; #1;
        n_cmp++; if (MemDB !== 16'h5A5A) begin n_bad++; $display("FAIL mid_bus_release: got %h need 5a5a", MemDB); end
        probe = 1'b0;
        mem[3] = 16'h0;
        rst_n = 1'b1; t0 = cyc; acks = 0;
        sb.push_back('{is_wr: 1'b1, addr: 23'h3, data: 16'hC0DE});
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (wr_ack) begin
                acks++;
                wr_req = 1'b0;
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    n_cmp++; if (cyc - t0 != LAT) begin n_bad++; $display("FAIL mid_retry_latency: got %0d need %0d", cyc - t0, LAT); end
                    n_cmp++; if (MemAdr !== e.addr) begin n_bad++; $display("FAIL mid_retry_memadr: got %h need %h", MemAdr, e.addr); end
                end
            end
        end
        n_cmp++; if (early != 0) begin n_bad++; $display("FAIL mid_aborted_ack: got %0d need 0", early); end
        n_cmp++; if (acks != 1) begin n_bad++; $display("FAIL mid_retry_acks: got %0d need 1", acks); end
        n_cmp++; if (mem[3] !== 16'hC0DE) begin n_bad++; $display("FAIL mid_model_word: got %h need c0de", mem[3]); end
        sb.delete();
    endtask

    task automatic test_streamed_reads;
        exp_t e;
        int   idx, t_last, n_ack, bad_data, bad_gap;
        for (int i = 0; i < 16; i++) mem[i] = 16'h1000 + 16'(i * 16'h0111);
        @(negedge clk);
        idx = 0; rd_addr = 23'h0; rd_req = 1'b1; t_last = cyc;
        sb.push_back('{is_wr: 1'b0, addr: 23'h0, data: mem[0]});
        n_ack = 0; bad_data = 0; bad_gap = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (rd_ack) begin
                if (sb.size() == 0) begin
                    bad_data++;
                end else begin
                    e = sb.pop_front();
                    if (rd_data !== e.data || MemAdr !== e.addr) begin
                        bad_data++;
                        $display("FAIL stream_data: got %h@%h need %h@%h", rd_data, MemAdr, e.data, e.addr);
                    end
                end
                if (cyc - t_last != ((n_ack == 0) ? LAT : SPACING)) bad_gap++;
                t_last = cyc;
                n_ack++;
                idx++;
                if (idx < 16) begin
                    rd_addr = 23'(idx);
                    sb.push_back('{is_wr: 1'b0, addr: 23'(idx), data: mem[idx]});
                end else begin
                    rd_req = 1'b0;
                end
            end
        end
        n_cmp++; if (n_ack != 16) begin n_bad++; $display("FAIL stream_ack_count: got %0d need 16", n_ack); end
        n_cmp++; if (bad_data != 0) begin n_bad++; $display("FAIL stream_data_total: got %0d bad need 0", bad_data); end
        n_cmp++; if (bad_gap != 0) begin n_bad++; $display("FAIL stream_spacing: got %0d bad gaps need 0", bad_gap); end
        n_cmp++; if (sb.size() != 0) begin n_bad++; $display("FAIL stream_pending: got %0d left need 0", sb.size()); end
        sb.delete();
    endtask

    initial begin
        for (int i = 0; i < 32; i++) mem[i] = 16'h0;
        test_reset();
        test_single_read();
        test_single_write();
        test_back_to_back();
        test_reset_mid_access();
        test_streamed_reads();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
